// File: rtl/dataflow_sched_pkg.sv
// Shared types and constants for the dataflow sync scheduler.
package dataflow_sched_pkg;

  // Stall watchdog states; STALLED is left only through ap_rst.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STALLED = 2'd2
  } wd_state_t;

  // Width of the in-flight iteration counter (MAX_INFLIGHT is limited to 1..15).
  localparam int INFLIGHT_W = 4;

  // Width of the watchdog cycle counter; it must be able to hold STALL_LIMIT-1.
  function automatic int stall_cnt_w(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sync_join.sv
// Generic sticky-bit join: remembers which inputs have fired since the last
// clear and reports when every input has fired, counting the current cycle.
module sync_join #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_set_en,
  input  logic [W-1:0] i_bits,
  input  logic         i_clear,
  output logic [W-1:0] o_sticky,
  output logic         o_all
);

  logic [W-1:0] r_sticky;

  // Clear has priority over set so a completed join starts the next round empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky <= '0;
    end else if (i_clear) begin
      r_sticky <= '0;
    end else if (i_set_en) begin
      r_sticky <= r_sticky | i_bits;
    end
  end

  assign o_sticky = r_sticky;
  assign o_all    = &(r_sticky | i_bits);

endmodule

// File: rtl/dataflow_sync_scheduler.sv
// Top-level dataflow controller: fans ap_start out to N_PROC processes, joins
// their ready/done into one top handshake, bounds in-flight iterations and
// runs a stall watchdog.
//
// Handshake semantics: a process accepts an iteration in the cycle where its
// proc_ap_start and proc_ap_ready are both high; the top accepts (ap_ready) in
// the cycle the last outstanding process accepts. A process holds proc_ap_done
// until it sees proc_ap_continue; the top retires an iteration in the cycle
// ap_done and ap_continue are both high, and that is the only cycle in which
// proc_ap_continue is driven high.
module dataflow_sync_scheduler
  import dataflow_sched_pkg::*;
#(
  parameter int N_PROC       = 2,
  parameter int MAX_INFLIGHT = 2,    // 1..15
  parameter int STALL_LIMIT  = 1024,
  parameter int ITER_W       = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic                  ap_continue,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic [N_PROC-1:0]     proc_ap_start,
  input  logic [N_PROC-1:0]     proc_ap_ready,
  input  logic [N_PROC-1:0]     proc_ap_done,
  input  logic [N_PROC-1:0]     proc_ap_idle,
  output logic [N_PROC-1:0]     proc_ap_continue,
  output logic [N_PROC-1:0]     ready_count,
  output logic [ITER_W-1:0]     iter_count,
  output logic                  stall,
  output wd_state_t             dbg_state,
  output logic [INFLIGHT_W-1:0] dbg_inflight,
  output logic [N_PROC-1:0]     dbg_done_latch
);

  localparam int                     STALL_CNT_W = stall_cnt_w(STALL_LIMIT);
  localparam logic [INFLIGHT_W-1:0]  MAX_INFL    = INFLIGHT_W'(MAX_INFLIGHT);
  localparam logic [STALL_CNT_W-1:0] STALL_LAST  = STALL_CNT_W'(STALL_LIMIT - 1);

  logic [INFLIGHT_W-1:0]  r_inflight;
  logic [ITER_W-1:0]      r_iter_count;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  wd_state_t              r_state;

  wd_state_t              w_state_nxt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic                   w_can_start;
  logic                   w_ready_all;
  logic                   w_done_all;
  logic                   w_all_ready;
  logic                   w_all_done;
  logic                   w_retire;
  logic                   w_busy;
  logic                   w_progress;
  logic [N_PROC-1:0]      w_ready_count;
  logic [N_PROC-1:0]      w_done_latch;

  // Handshake outputs are forced quiet while ap_rst is high, even if ap_start
  // or a held proc_ap_done is present on the inputs.
  assign w_can_start = ~ap_rst & ap_start & (r_inflight < MAX_INFL);
  assign w_all_ready = w_can_start & w_ready_all;
  assign w_all_done  = ~ap_rst & w_done_all;
  assign w_retire    = w_all_done & ap_continue;
  assign w_busy      = (r_inflight != '0);
  assign w_progress  = |(proc_ap_ready | proc_ap_done);

  // Ready join: a process's ready only counts while a start is being offered.
  sync_join #(.W(N_PROC)) u_ready_join (
    .i_clk    (ap_clk),
    .i_rst    (ap_rst),
    .i_set_en (w_can_start),
    .i_bits   (proc_ap_ready),
    .i_clear  (w_all_ready),
    .o_sticky (w_ready_count),
    .o_all    (w_ready_all)
  );

  // Done join: done bits latch unconditionally and clear on retirement.
  sync_join #(.W(N_PROC)) u_done_join (
    .i_clk    (ap_clk),
    .i_rst    (ap_rst),
    .i_set_en (1'b1),
    .i_bits   (proc_ap_done),
    .i_clear  (w_retire),
    .o_sticky (w_done_latch),
    .o_all    (w_done_all)
  );

  assign proc_ap_start    = {N_PROC{w_can_start}} & ~w_ready_count;
  assign proc_ap_continue = {N_PROC{w_retire}};
  assign ap_ready         = w_all_ready;
  assign ap_done          = w_all_done;
  assign ap_idle          = ap_rst | (&proc_ap_idle & ~w_busy & ~ap_start);
  assign ready_count      = w_ready_count;
  assign iter_count       = r_iter_count;
  assign stall            = (r_state == STALLED);
  assign dbg_state        = r_state;
  assign dbg_inflight     = r_inflight;
  assign dbg_done_latch   = w_done_latch;

  // In-flight count: accept adds one, retire removes one, both together cancel.
  // A retire with nothing in flight is a protocol error and leaves the count at 0.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_all_ready, w_retire})
        2'b10:   r_inflight <= r_inflight + INFLIGHT_W'(1);
        2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - INFLIGHT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Completed-iteration counter, wraps naturally at 2^ITER_W.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_iter_count <= '0;
    end else if (w_retire) begin
      r_iter_count <= r_iter_count + ITER_W'(1);
    end
  end

  // Watchdog state and cycle counter registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Watchdog next state: count quiet cycles while busy, trip after STALL_LIMIT.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    case (r_state)
      IDLE: begin
        w_stall_cnt_nxt = '0;
        if (ap_start | w_busy) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (~ap_start & ~w_busy) begin
          w_state_nxt     = IDLE;
          w_stall_cnt_nxt = '0;
        end else if (w_progress) begin
          w_stall_cnt_nxt = '0;
        end else if (r_stall_cnt == STALL_LAST) begin
          w_state_nxt     = STALLED;
          w_stall_cnt_nxt = '0;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt + STALL_CNT_W'(1);
        end
      end
      STALLED: begin
        w_stall_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_stall_cnt_nxt = '0;
      end
    endcase
  end

  // A retirement with no iteration in flight means a process signalled done
  // for work it was never given.
  a_no_retire_when_empty: assert property (
    @(posedge ap_clk) disable iff (ap_rst)
    !(w_retire && !w_all_ready && (r_inflight == '0))
  ) else $error("dataflow_sync_scheduler: retire with no iteration in flight");

endmodule
